cpu_ctrl_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the 8-bit single-cycle CPU datapath: fetches each instruction

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/cpu_ctrl_decoder.sv | 52 +++++
 rtl/cpu_ctrl_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cpu_ctrl_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU selects and FSM encoding for the control sequencer
//
// Purpose : common definitions imported by cpu_ctrl_decoder and cpu_ctrl_sequencer.
// Ports   : none (package).
`timescale 1ns/1ps
package cpu_ctrl_pkg;

  // Opcode field values, INSTR[31:24]
  localparam logic [7:0] OPC_LOADI = 8'd0;
  localparam logic [7:0] OPC_MOV   = 8'd1;
  localparam logic [7:0] OPC_ADD   = 8'd2;
  localparam logic [7:0] OPC_SUB   = 8'd3;
  localparam logic [7:0] OPC_AND   = 8'd4;
  localparam logic [7:0] OPC_OR    = 8'd5;
  localparam logic [7:0] OPC_J     = 8'd6;
  localparam logic [7:0] OPC_BEQ   = 8'd7;

  // ALU function selects
  localparam logic [2:0] ALUOP_FWD = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_ctrl_decoder.sv
// rtl/cpu_ctrl_decoder.sv - combinational opcode decoder for the control sequencer
//
// Purpose : maps an opcode to datapath controls; unknown opcodes flag illegal and
//           decode as a NOP (no write, no jump/branch).
// Ports   : opcode    in  OPCODE_W  instruction opcode field
//           aluop     out ALUOP_W   ALU function select
//           imselect  out 1         immediate to ALU DATA2
//           negselect out 1         negate REGOUT2
//           wr        out 1         instruction writes reg_file
//           is_j      out 1         unconditional jump
//           is_beq    out 1         branch-if-equal
//           illegal   out 1         opcode outside the defined set
`timescale 1ns/1ps
module cpu_ctrl_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                imselect,
  output logic                negselect,
  output logic                wr,
  output logic                is_j,
  output logic                is_beq,
  output logic                illegal
);

  always_comb begin
    aluop     = ALUOP_W'(ALUOP_FWD);
    imselect  = 1'b0;
    negselect = 1'b0;
    wr        = 1'b0;
    is_j      = 1'b0;
    is_beq    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPCODE_W'(OPC_LOADI): begin imselect = 1'b1; wr = 1'b1; end
      OPCODE_W'(OPC_MOV):   wr = 1'b1;
      OPCODE_W'(OPC_ADD):   begin aluop = ALUOP_W'(ALUOP_ADD); wr = 1'b1; end
      OPCODE_W'(OPC_SUB):   begin aluop = ALUOP_W'(ALUOP_ADD); negselect = 1'b1; wr = 1'b1; end
      OPCODE_W'(OPC_AND):   begin aluop = ALUOP_W'(ALUOP_AND); wr = 1'b1; end
      OPCODE_W'(OPC_OR):    begin aluop = ALUOP_W'(ALUOP_OR);  wr = 1'b1; end
      OPCODE_W'(OPC_J):     is_j = 1'b1;
      // beq compares by subtraction so the ALU drives ZERO
      OPCODE_W'(OPC_BEQ):   begin aluop = ALUOP_W'(ALUOP_ADD); negselect = 1'b1; is_beq = 1'b1; end
      default:              illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// rtl/cpu_ctrl_sequencer.sv - multi-cycle fetch/decode/exec/writeback control FSM
//
// Purpose : fetches instructions over a busywait handshake, holds them in INSTR and
//           drives registered ALU/mux/reg_file/PC controls, one instruction per
//           FETCH-DECODE-EXEC-WB pass.
// Config  : CTRL_ILLEGAL_TRAP_EN - when defined, an undefined opcode faults and halts;
//           otherwise it runs as a NOP (PC+4, no write).
// Ports   : CLK           in   1   clock, rising edge
//           RESET         in   1   asynchronous active-low reset
//           IMEM_READ     out  1   fetch request (FETCH only)
//           IMEM_BUSYWAIT in   1   1 = IMEM_INSTR not yet valid
//           IMEM_INSTR    in   32  fetched word
//           INSTR         out  32  instruction register
//           ZERO          in   1   ALU zero flag
//           ALUOP         out  3   ALU select
//           IMSELECT      out  1   immediate to ALU DATA2
//           NEGSELECT     out  1   negate REGOUT2
//           WRITEENABLE   out  1   reg_file write strobe (WB only)
//           PC_EN         out  1   PC update strobe (WB only)
//           PC_SEL        out  1   0 = PC+4, 1 = target
//           HALTED        out  1   parked in HALT
//           FAULT         out  1   sticky fault flag
`timescale 1ns/1ps
module cpu_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 8,
  parameter int ALUOP_W       = 3,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic               IMEM_READ,
  input  logic               IMEM_BUSYWAIT,
  input  logic [31:0]        IMEM_INSTR,
  output logic [31:0]        INSTR,
  input  logic               ZERO,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               IMSELECT,
  output logic               NEGSELECT,
  output logic               WRITEENABLE,
  output logic               PC_EN,
  output logic               PC_SEL,
  output logic               HALTED,
  output logic               FAULT
);

  state_t             state;
  logic [7:0]         fetch_cnt;
  logic               wr_q;
  logic               is_j_q;
  logic               is_beq_q;

  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_imselect;
  logic               dec_negselect;
  logic               dec_wr;
  logic               dec_is_j;
  logic               dec_is_beq;
  logic               dec_illegal;

  cpu_ctrl_decoder #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decoder (
    .opcode    (INSTR[31 -: OPCODE_W]),
    .aluop     (dec_aluop),
    .imselect  (dec_imselect),
    .negselect (dec_negselect),
    .wr        (dec_wr),
    .is_j      (dec_is_j),
    .is_beq    (dec_is_beq),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      fetch_cnt   <= '0;
      INSTR       <= '0;
      IMEM_READ   <= 1'b0;
      ALUOP       <= '0;
      IMSELECT    <= 1'b0;
      NEGSELECT   <= 1'b0;
      WRITEENABLE <= 1'b0;
      PC_EN       <= 1'b0;
      PC_SEL      <= 1'b0;
      HALTED      <= 1'b0;
      FAULT       <= 1'b0;
      wr_q        <= 1'b0;
      is_j_q      <= 1'b0;
      is_beq_q    <= 1'b0;
    end else begin
      // WB strobes are single-cycle; only the EXEC->WB edge raises them
      WRITEENABLE <= 1'b0;
      PC_EN       <= 1'b0;
      PC_SEL      <= 1'b0;
      case (state)
        ST_IDLE: begin
          IMEM_READ <= 1'b1;
          state     <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            INSTR     <= IMEM_INSTR;
            fetch_cnt <= '0;
            IMEM_READ <= 1'b0;
            state     <= ST_DECODE;
          end else if (fetch_cnt == 8'(FETCH_TIMEOUT - 1)) begin
            // this is the FETCH_TIMEOUT-th busy cycle: give up
            fetch_cnt <= fetch_cnt + 8'd1;
            IMEM_READ <= 1'b0;
            FAULT     <= 1'b1;
            HALTED    <= 1'b1;
            state     <= ST_HALT;
          end else begin
            fetch_cnt <= fetch_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (dec_illegal) begin
            FAULT  <= 1'b1;
            HALTED <= 1'b1;
            state  <= ST_HALT;
          end else
`endif
          begin
            ALUOP     <= dec_aluop;
            IMSELECT  <= dec_imselect;
            NEGSELECT <= dec_negselect;
            // undefined opcodes degrade to a NOP: PC+4, no write
            wr_q      <= dec_wr & ~dec_illegal;
            is_j_q    <= dec_is_j & ~dec_illegal;
            is_beq_q  <= dec_is_beq & ~dec_illegal;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ZERO has settled by the end of the EXEC cycle; capturing it here
          // keeps PC_SEL registered and stable for the whole WB cycle
          WRITEENABLE <= wr_q;
          PC_EN       <= 1'b1;
          PC_SEL      <= is_j_q | (is_beq_q & ZERO);
          state       <= ST_WB;
        end
        ST_WB: begin
          IMEM_READ <= 1'b1;
          state     <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          IMEM_READ <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// tb/tb_cpu_ctrl_sequencer.sv - directed self-checking bench for cpu_ctrl_sequencer
`timescale 1ns/1ps
module tb_cpu_ctrl_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        IMEM_READ;
  logic        IMEM_BUSYWAIT = 1'b1;
  logic [31:0] IMEM_INSTR = 32'h0;
  logic [31:0] INSTR;
  logic        ZERO = 1'b0;
  logic [2:0]  ALUOP;
  logic        IMSELECT;
  logic        NEGSELECT;
  logic        WRITEENABLE;
  logic        PC_EN;
  logic        PC_SEL;
  logic        HALTED;
  logic        FAULT;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_instr = 32'h0;

  cpu_ctrl_sequencer dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_READ     (IMEM_READ),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_INSTR    (IMEM_INSTR),
    .INSTR         (INSTR),
    .ZERO          (ZERO),
    .ALUOP         (ALUOP),
    .IMSELECT      (IMSELECT),
    .NEGSELECT     (NEGSELECT),
    .WRITEENABLE   (WRITEENABLE),
    .PC_EN         (PC_EN),
    .PC_SEL        (PC_SEL),
    .HALTED        (HALTED),
    .FAULT         (FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Called at the start of a FETCH cycle; holds busywait for nbusy cycles,
  // then presents w and returns at the start of DECODE.
  task automatic present(input logic [31:0] w, input int nbusy);
    IMEM_BUSYWAIT = 1'b1;
    IMEM_INSTR    = 32'hDEADBEEF;
    repeat (nbusy) tick();
    IMEM_BUSYWAIT = 1'b0;
    IMEM_INSTR    = w;
    tick();
    last_instr    = w;
    IMEM_INSTR    = 32'hA5A5A5A5;
  endtask

  // Asserts reset asynchronously, then returns at the start of the first FETCH cycle.
  task automatic test_reset;
    logic [42:0] v;
    #2;
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b1;
    #1;
    v = {IMEM_READ, INSTR, ALUOP, IMSELECT, NEGSELECT, WRITEENABLE, PC_EN, PC_SEL, HALTED, FAULT};
    n_checks++; if (v !== 43'h0) begin n_fail++; $display("FAIL reset_async_outputs: got %h want 0", v); end
    tick();
    tick();
    v = {IMEM_READ, INSTR, ALUOP, IMSELECT, NEGSELECT, WRITEENABLE, PC_EN, PC_SEL, HALTED, FAULT};
    n_checks++; if (v !== 43'h0) begin n_fail++; $display("FAIL reset_held_outputs: got %h want 0", v); end
    RESET = 1'b1;
    last_instr = 32'h0;
    tick();
    n_checks++; if (IMEM_READ !== 1'b1) begin n_fail++; $display("FAIL reset_to_fetch_read: got %b want 1", IMEM_READ); end
  endtask

  task automatic test_loadi;
    ZERO = 1'b0;
    present(32'h00040009, 0);
    n_checks++; if (INSTR !== 32'h00040009) begin n_fail++; $display("FAIL loadi_instr: got %h want 00040009", INSTR); end
    n_checks++; if (IMEM_READ !== 1'b0) begin n_fail++; $display("FAIL loadi_read_decode: got %b want 0", IMEM_READ); end
    tick();
    n_checks++; if ({ALUOP, IMSELECT, NEGSELECT} !== 5'b000_1_0) begin n_fail++; $display("FAIL loadi_ctrl: got %b want 00010", {ALUOP, IMSELECT, NEGSELECT}); end
    n_checks++; if ({WRITEENABLE, PC_EN} !== 2'b00) begin n_fail++; $display("FAIL loadi_exec_strobes: got %b want 00", {WRITEENABLE, PC_EN}); end
    tick();
    n_checks++; if ({WRITEENABLE, PC_EN, PC_SEL} !== 3'b110) begin n_fail++; $display("FAIL loadi_wb_strobes: got %b want 110", {WRITEENABLE, PC_EN, PC_SEL}); end
    tick();
    n_checks++; if ({IMEM_READ, WRITEENABLE, PC_EN} !== 3'b100) begin n_fail++; $display("FAIL loadi_refetch: got %b want 100", {IMEM_READ, WRITEENABLE, PC_EN}); end
  endtask

  task automatic test_sub_busywait;
    IMEM_BUSYWAIT = 1'b1;
    IMEM_INSTR    = 32'hDEADBEEF;
    tick();
    n_checks++; if ({IMEM_READ, INSTR} !== {1'b1, 32'h00040009}) begin n_fail++; $display("FAIL sub_busy_hold: got %b/%h want 1/00040009", IMEM_READ, INSTR); end
    tick();
    tick();
    n_checks++; if ({IMEM_READ, INSTR} !== {1'b1, 32'h00040009}) begin n_fail++; $display("FAIL sub_busy_c3: got %b/%h want 1/00040009", IMEM_READ, INSTR); end
    IMEM_BUSYWAIT = 1'b0;
    IMEM_INSTR    = 32'h03010203;
    tick();
    IMEM_INSTR    = 32'hA5A5A5A5;
    last_instr    = 32'h03010203;
    n_checks++; if ({IMEM_READ, INSTR} !== {1'b0, 32'h03010203}) begin n_fail++; $display("FAIL sub_instr_c4: got %b/%h want 0/03010203", IMEM_READ, INSTR); end
    tick();
    n_checks++; if ({ALUOP, IMSELECT, NEGSELECT} !== 5'b001_0_1) begin n_fail++; $display("FAIL sub_ctrl: got %b want 00101", {ALUOP, IMSELECT, NEGSELECT}); end
    tick();
    n_checks++; if ({WRITEENABLE, PC_EN, PC_SEL, NEGSELECT} !== 4'b1101) begin n_fail++; $display("FAIL sub_wb_cycle7: got %b want 1101", {WRITEENABLE, PC_EN, PC_SEL, NEGSELECT}); end
    tick();
  endtask

  task automatic test_alu_ops;
    logic [31:0] w;
    logic [2:0]  ea;
    logic        ei, en, ew, ep, z, chk;
    for (int i = 0; i < 7; i++) begin
      chk = 1'b1; ei = 1'b0; en = 1'b0; ew = 1'b1; ep = 1'b0; z = 1'b0; ea = 3'b000;
      case (i)
        0: w = 32'h01020300;
        1: begin w = 32'h02010203; ea = 3'b001; end
        2: begin w = 32'h04010203; ea = 3'b010; end
        3: begin w = 32'h05010203; ea = 3'b011; z = 1'b1; end
        4: begin w = 32'h06000004; chk = 1'b0; ew = 1'b0; ep = 1'b1; end
        5: begin w = 32'h070001FC; ea = 3'b001; en = 1'b1; ew = 1'b0; ep = 1'b1; z = 1'b1; end
        default: begin w = 32'h070001FC; ea = 3'b001; en = 1'b1; ew = 1'b0; ep = 1'b0; z = 1'b0; end
      endcase
      ZERO = z;
      present(w, i % 3);
      n_checks++; if (INSTR !== w) begin n_fail++; $display("FAIL op%0d_instr: got %h want %h", i, INSTR, w); end
      tick();
      if (chk) begin
        n_checks++; if ({ALUOP, IMSELECT, NEGSELECT} !== {ea, ei, en}) begin n_fail++; $display("FAIL op%0d_ctrl: got %b want %b", i, {ALUOP, IMSELECT, NEGSELECT}, {ea, ei, en}); end
      end
      tick();
      n_checks++; if ({WRITEENABLE, PC_EN, PC_SEL} !== {ew, 1'b1, ep}) begin n_fail++; $display("FAIL op%0d_wb: got %b want %b", i, {WRITEENABLE, PC_EN, PC_SEL}, {ew, 1'b1, ep}); end
      tick();
      n_checks++; if ({IMEM_READ, WRITEENABLE, PC_EN, PC_SEL} !== 4'b1000) begin n_fail++; $display("FAIL op%0d_refetch: got %b want 1000", i, {IMEM_READ, WRITEENABLE, PC_EN, PC_SEL}); end
    end
    ZERO = 1'b0;
  endtask

  task automatic test_illegal;
    logic strobes;
    ZERO = 1'b1;
    present(32'hFF000000, 0);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_checks++; if ({HALTED, FAULT, WRITEENABLE, PC_EN} !== 4'b1100) begin n_fail++; $display("FAIL illegal_trap: got %b want 1100", {HALTED, FAULT, WRITEENABLE, PC_EN}); end
    strobes = 1'b0;
    repeat (5) begin tick(); strobes |= IMEM_READ | WRITEENABLE | PC_EN | PC_SEL; end
    n_checks++; if ({strobes, INSTR} !== {1'b0, 32'hFF000000}) begin n_fail++; $display("FAIL illegal_halt_quiet: got %b/%h want 0/ff000000", strobes, INSTR); end
    ZERO = 1'b0;
    test_reset();
`else
    n_checks++; if ({HALTED, FAULT} !== 2'b00) begin n_fail++; $display("FAIL illegal_nofault: got %b want 00", {HALTED, FAULT}); end
    tick();
    strobes = WRITEENABLE;
    n_checks++; if ({strobes, PC_EN, PC_SEL} !== 3'b010) begin n_fail++; $display("FAIL illegal_nop_wb: got %b want 010", {strobes, PC_EN, PC_SEL}); end
    ZERO = 1'b0;
    tick();
`endif
  endtask

  task automatic test_mid_reset;
    present(32'h02010203, 0);
    tick();
    n_checks++; if (ALUOP !== 3'b001) begin n_fail++; $display("FAIL midrst_exec_aluop: got %b want 001", ALUOP); end
    test_reset();
    n_checks++; if ({WRITEENABLE, PC_EN, INSTR} !== 34'h0) begin n_fail++; $display("FAIL midrst_no_wb: got %b%b/%h want 00/0", WRITEENABLE, PC_EN, INSTR); end
  endtask

  task automatic test_timeout;
    logic strobes;
    IMEM_BUSYWAIT = 1'b1;
    IMEM_INSTR    = 32'h12345678;
    repeat (254) tick();
    n_checks++; if ({IMEM_READ, FAULT, HALTED} !== 3'b100) begin n_fail++; $display("FAIL timeout_c255_still_fetch: got %b want 100", {IMEM_READ, FAULT, HALTED}); end
    tick();
    n_checks++; if ({IMEM_READ, FAULT, HALTED} !== 3'b011) begin n_fail++; $display("FAIL timeout_fault: got %b want 011", {IMEM_READ, FAULT, HALTED}); end
    IMEM_BUSYWAIT = 1'b0;
    IMEM_INSTR    = 32'h00040009;
    strobes = 1'b0;
    repeat (10) begin tick(); strobes |= IMEM_READ | WRITEENABLE | PC_EN | PC_SEL; end
    n_checks++; if ({strobes, FAULT, HALTED} !== 3'b011) begin n_fail++; $display("FAIL timeout_halt_quiet: got %b want 011", {strobes, FAULT, HALTED}); end
    n_checks++; if (INSTR !== last_instr) begin n_fail++; $display("FAIL timeout_instr_kept: got %h want %h", INSTR, last_instr); end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_sub_busywait();
    test_alu_ops();
    test_illegal();
    test_mid_reset();
    test_timeout();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
